// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory responder with wait states and ready pulse
module data_mem_responder #(
  parameter int W           = 32,
  parameter int AW          = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          rw,
  input  logic [AW-1:0] addbus,
  input  logic [W-1:0]  datain,
  output logic [W-1:0]  dataout,
  output logic          ready,
  output logic          err,
  output logic          busy
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] wait_cnt;
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [W-1:0]  data_q;
  logic          accept;
  logic          do_access;
  logic          in_range;
  logic [IW-1:0] mem_idx;

  logic [W-1:0]  mem [DEPTH];

  // Range check uses one extra bit so DEPTH == 2**AW still compares correctly.
  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
  assign mem_idx  = addr_q[IW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    accept    = (state == S_IDLE) && en;
    do_access = (state == S_ACCESS);
  end

  // Cleared on every accept, so the count never exceeds WAIT_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      rw_q   <= rw;
      addr_q <= addbus;
      data_q <= datain;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataout <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      ready <= do_access;
      err   <= do_access && !in_range;
      if (do_access && rw_q) begin
        dataout <= in_range ? mem[mem_idx] : '0;
      end
    end
  end

  // Storage has no reset; an async reset forces IDLE, which cancels a pending write.
  always_ff @(posedge clk) begin
    if (do_access && !rw_q && in_range) begin
      mem[mem_idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (WAIT_CYCLES 2 and 0)
module tb_data_mem_responder;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          err;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en0 = 1'b0;
  logic        en1 = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] addbus = '0;
  logic [31:0] datain = '0;
  logic [31:0] dout0, dout1;
  logic        ready0, ready1, err0, err1, busy0, busy1;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mm[int];
  logic [31:0] dout_m[2];
  bit          dout_known[2];
  bit          prev_rdy[2];

  data_mem_responder #(.W(32), .AW(16), .DEPTH(1024), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .en(en0), .rw(rw), .addbus(addbus), .datain(datain),
    .dataout(dout0), .ready(ready0), .err(err0), .busy(busy0)
  );

  data_mem_responder #(.W(32), .AW(16), .DEPTH(1024), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .rw(rw), .addbus(addbus), .datain(datain),
    .dataout(dout1), .ready(ready1), .err(err1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_dut(input int d, input logic rdy, input logic er, input logic [31:0] dq);
    exp_t e;
    bit   empty;
    if (rdy) begin
      check($sformatf("dut%0d_no_back_to_back_ready", d), 32'(prev_rdy[d]), 32'd0);
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_ready: got ready=1 expected none (cycle %0d)", d, cyc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("dut%0d_ready_cycle", d), 32'(cyc), 32'(e.cyc));
        check($sformatf("dut%0d_err", d), 32'(er), 32'(e.err));
        if (e.chk) check($sformatf("dut%0d_dataout", d), dq, e.data);
      end
    end else begin
      check($sformatf("dut%0d_err_outside_done", d), 32'(er), 32'd0);
    end
    prev_rdy[d] = rdy;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_dut(0, ready0, err0, dout0);
      mon_dut(1, ready1, err1, dout1);
    end
  end

  // Reference model: expected response computed from the access rules, pushed at issue time.
  function automatic exp_t model(input int d, input bit rd, input logic [15:0] a,
                                 input logic [31:0] dat, input int accept_edge);
    exp_t e;
    int   key = d * 65536 + int'(a);
    int   wc  = (d == 0) ? 2 : 0;
    e.cyc  = accept_edge + wc + 1;
    e.err  = (a >= 16'd1024);
    e.data = '0;
    e.chk  = 1'b0;
    if (rd) begin
      if (a >= 16'd1024) begin
        e.chk = 1'b1;
        dout_m[d] = '0;
        dout_known[d] = 1'b1;
      end else if (mm.exists(key)) begin
        e.data = mm[key];
        e.chk  = 1'b1;
        dout_m[d] = mm[key];
        dout_known[d] = 1'b1;
      end else begin
        dout_known[d] = 1'b0;
      end
    end else begin
      if (a < 16'd1024) mm[key] = dat;
      e.data = dout_m[d];
      e.chk  = dout_known[d];
    end
    return e;
  endfunction

  task automatic req(input int d, input bit rd, input logic [15:0] a, input logic [31:0] dat);
    exp_t e;
    int   n = 0;
    int   guard = 0;
    int   wc = (d == 0) ? 2 : 0;
    e = model(d, rd, a, dat, cyc + 1);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    rw = rd; addbus = a; datain = dat;
    if (d == 0) en0 = 1'b1;
    else        en1 = 1'b1;
    @(posedge clk); #1;
    en0 = 1'b0; en1 = 1'b0;
    rw = 1'($urandom); addbus = 16'($urandom); datain = $urandom;
    while (((d == 0) ? busy0 : busy1) && guard < 40) begin
      n++;
      @(posedge clk); #1;
      guard++;
    end
    check($sformatf("dut%0d_busy_cycles", d), 32'(n), 32'(wc + 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          start;
    logic [15:0] a;
    exp_t        e;
    dout_m[0] = '0; dout_m[1] = '0;
    dout_known[0] = 1'b1; dout_known[1] = 1'b1;
    prev_rdy[0] = 1'b0; prev_rdy[1] = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (10) begin
      @(negedge clk);
      check("idle_ready", 32'(ready0), 32'd0);
      check("idle_busy", 32'(busy0), 32'd0);
      check("idle_dataout", dout0, 32'd0);
    end
    @(posedge clk); #1;

    // Basic write/read
    req(0, 1'b0, 16'd5, 32'hDEADBEEF);
    req(0, 1'b1, 16'd5, 32'h0);

    // Out-of-range handling, no aliasing onto 1023
    req(0, 1'b0, 16'd1023, 32'hA5A50001);
    req(0, 1'b1, 16'd1024, 32'h0);
    req(0, 1'b0, 16'hFFFF, 32'h0BAD0BAD);
    req(0, 1'b1, 16'd1023, 32'h0);

    // Reset during WAIT aborts the write
    req(0, 1'b0, 16'd7, 32'h12345678);
    rw = 1'b0; addbus = 16'd7; datain = 32'h0; en0 = 1'b1;
    @(posedge clk); #1 en0 = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    dout_m[0] = '0; dout_known[0] = 1'b1;
    dout_m[1] = '0; dout_known[1] = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    check("post_reset_busy", 32'(busy0), 32'd0);
    check("post_reset_ready", 32'(ready0), 32'd0);
    check("post_reset_dataout", dout0, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    req(0, 1'b1, 16'd7, 32'h0);

    // en held high: accepts every WAIT_CYCLES+3 edges
    start = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e = model(0, 1'b1, 16'd5, 32'h0, start + 5 * i);
      q0.push_back(e);
    end
    rw = 1'b1; addbus = 16'd5; en0 = 1'b1;
    repeat (15) @(posedge clk);
    #1 en0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Zero wait states
    req(1, 1'b0, 16'd3, 32'hCAFEF00D);
    req(1, 1'b1, 16'd3, 32'h0);
    req(1, 1'b1, 16'd2000, 32'h0);

    // Random traffic on both instances
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 16'($urandom_range(1024, 65535));
        1:       a = 16'd1023;
        default: a = 16'($urandom_range(0, 15));
      endcase
      req((i % 5 == 4) ? 1 : 0, 1'($urandom), a, $urandom);
    end

    repeat (4) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
